// File: rtl/load_mem_server.sv
// rtl/load_mem_server.sv - MemRequest load-path server: fetches a 64-byte line over a beat bus into a 512-bit buffer
// Optional feature macro: LOAD_LINE_HIT_EN (one-entry line tag; a repeat request to the
// same line completes without a bus fetch). Default build: every request fetches.
module load_mem_server #(
   parameter int DATA_WIDTH = 64,
   parameter int LINE_BYTES = 64,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_send_fetch_req_in,
   input  logic [ADDR_WIDTH-1:0]   load_fetch_ad,
   output logic                    load_mem_req_completed,
   output logic [LINE_BYTES*8-1:0] load_mem_buffer,
   output logic [6:0]              load_buf_offset,
   output logic [6:0]              load_num_bytes,
   output logic                    bus_req,
   output logic [ADDR_WIDTH-1:0]   bus_addr,
   input  logic                    bus_ack,
   input  logic                    bus_resp_valid,
   input  logic [DATA_WIDTH-1:0]   bus_resp_data
);

   localparam int BEATS = LINE_BYTES * 8 / DATA_WIDTH;
   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TAG_W = ADDR_WIDTH - OFF_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_FILL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [CNT_W-1:0]          r_beat_cnt;
   logic [LINE_BYTES*8-1:0]   r_buffer;
   logic [6:0]                r_offset;
   logic [6:0]                r_num_bytes;
   // Set when the client abandons the handshake mid-fetch; DONE then lasts one cycle.
   logic                      r_dropped;

   logic                      w_accept;
   logic                      w_hit;
   logic                      w_beat;
   logic                      w_last_beat;
   logic                      w_ack_seen;

`ifdef LOAD_LINE_HIT_EN
   logic                      r_tag_valid;
   logic [TAG_W-1:0]          r_tag;

   assign w_hit = r_tag_valid && (r_tag == load_fetch_ad[ADDR_WIDTH-1:OFF_W]);
`else
   assign w_hit = 1'b0;
`endif

   assign w_accept    = (r_state == S_IDLE) && load_send_fetch_req_in;
   assign w_ack_seen  = (r_state == S_REQ) && bus_ack;
   // Beats outside FILL (IDLE, REQ, or the ack cycle itself) are deliberately dropped.
   assign w_beat      = (r_state == S_FILL) && bus_resp_valid;
   assign w_last_beat = w_beat && (r_beat_cnt == CNT_W'(BEATS - 1));

   // State register; async reset forces IDLE so bus_req drops without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_state_nxt            = r_state;
      bus_req                = 1'b0;
      load_mem_req_completed = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (load_send_fetch_req_in) begin
               w_state_nxt = w_hit ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            bus_req = 1'b1;
            if (bus_ack) begin
               w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            if (w_last_beat) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            load_mem_req_completed = 1'b1;
            if (!load_send_fetch_req_in || r_dropped) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Request address latch and mid-fetch abandon tracking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr    <= '0;
         r_dropped <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr    <= load_fetch_ad;
            r_dropped <= 1'b0;
         end else if (((r_state == S_REQ) || (r_state == S_FILL)) && !load_send_fetch_req_in) begin
            r_dropped <= 1'b1;
         end
      end
   end

   // Beat counter and line assembly: beat k lands in line bytes 8k..8k+7, little-endian lanes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_beat_cnt <= '0;
         r_buffer   <= '0;
      end else begin
         if (w_ack_seen) begin
            r_beat_cnt <= '0;
         end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
         end
         if (w_beat) begin
            for (int k = 0; k < BEATS; k++) begin
               if (r_beat_cnt == CNT_W'(k)) begin
                  r_buffer[k*DATA_WIDTH +: DATA_WIDTH] <= bus_resp_data;
               end
            end
         end
      end
   end

   // Offset and valid byte count published together with completion (fill end or line hit).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_offset    <= '0;
         r_num_bytes <= '0;
      end else begin
         if (w_last_beat) begin
            r_offset    <= 7'(r_addr[OFF_W-1:0]);
            r_num_bytes <= 7'(LINE_BYTES) - 7'(r_addr[OFF_W-1:0]);
         end else if (w_accept && w_hit) begin
            r_offset    <= 7'(load_fetch_ad[OFF_W-1:0]);
            r_num_bytes <= 7'(LINE_BYTES) - 7'(load_fetch_ad[OFF_W-1:0]);
         end
      end
   end

`ifdef LOAD_LINE_HIT_EN
   // Line tag records the most recently completed fill; a reset invalidates it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tag_valid <= 1'b0;
         r_tag       <= '0;
      end else if (w_last_beat) begin
         r_tag_valid <= 1'b1;
         r_tag       <= r_addr[ADDR_WIDTH-1:OFF_W];
      end
   end
`endif

   assign load_mem_buffer = r_buffer;
   assign load_buf_offset = r_offset;
   assign load_num_bytes  = r_num_bytes;
   assign bus_addr        = {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

endmodule

// File: tb/tb_load_mem_server.sv
// tb/tb_load_mem_server.sv - directed self-checking bench for load_mem_server
module tb_load_mem_server;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         send = 1'b0;
   logic [63:0]  fad = '0;
   logic         completed;
   logic [511:0] buffer;
   logic [6:0]   offset;
   logic [6:0]   num_bytes;
   logic         bus_req;
   logic [63:0]  bus_addr;
   logic         ack = 1'b0;
   logic         rvalid = 1'b0;
   logic [63:0]  rdata = '0;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [63:0] SEED1 = 64'h0706050403020100;
   localparam logic [63:0] SEED2 = 64'hA1B2C3D4E5F60718;
   localparam logic [63:0] SEED3 = 64'h1122334455667788;
   localparam logic [63:0] SEED4 = 64'hDEADBEEFCAFEF00D;
   localparam logic [63:0] SEED5 = 64'h0F1E2D3C4B5A6978;

   load_mem_server dut (
      .clk                    (clk),
      .reset                  (reset),
      .load_send_fetch_req_in (send),
      .load_fetch_ad          (fad),
      .load_mem_req_completed (completed),
      .load_mem_buffer        (buffer),
      .load_buf_offset        (offset),
      .load_num_bytes         (num_bytes),
      .bus_req                (bus_req),
      .bus_addr               (bus_addr),
      .bus_ack                (ack),
      .bus_resp_valid         (rvalid),
      .bus_resp_data          (rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] beat_data(input logic [63:0] seed, input int k);
      return seed + 64'(k) * 64'h0808080808080808;
   endfunction

   function automatic logic [511:0] exp_line(input logic [63:0] seed);
      logic [511:0] l;
      for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat_data(seed, k);
      return l;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [63:0] ad);
      send = 1'b1;
      fad  = ad;
      tick();
   endtask

   task automatic ack_after(input int n);
      repeat (n - 1) tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic send_beats(input int first, input int last, input int gap, input logic [63:0] seed);
      for (int k = first; k <= last; k++) begin
         rvalid = 1'b1;
         rdata  = beat_data(seed, k);
         tick();
         rvalid = 1'b0;
         rdata  = '0;
         if (k != last) repeat (gap) tick();
      end
   endtask

   initial begin
      logic [511:0] bytes_n;
      for (int n = 0; n < 64; n++) bytes_n[n*8 +: 8] = 8'(n);

      // reset state
      tick(); tick();
      chk("rst_buffer", buffer, '0);
      chk("rst_offset", offset, 0);
      chk("rst_num_bytes", num_bytes, 0);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_completed", completed, 0);
      reset = 1'b1;
      tick();

      // 1: aligned fetch, back-to-back beats
      request(64'h1000);
      chk("t1_bus_req", bus_req, 1);
      chk("t1_bus_addr", bus_addr, 64'h1000);
      ack_after(2);
      chk("t1_req_dropped_after_ack", bus_req, 0);
      send_beats(0, 6, 0, SEED1);
      chk("t1_not_yet_completed", completed, 0);
      send_beats(7, 7, 0, SEED1);
      chk("t1_completed", completed, 1);
      chk("t1_buffer", buffer, bytes_n);
      chk("t1_offset", offset, 0);
      chk("t1_num_bytes", num_bytes, 64);
      tick();
      chk("t1_completed_held", completed, 1);
      send = 1'b0;
      tick();
      chk("t1_completed_low", completed, 0);

      // 2: offset 63, gaps between beats
      request(64'h203F);
      chk("t2_bus_addr", bus_addr, 64'h2000);
      ack_after(3);
      send_beats(0, 7, 1, SEED2);
      chk("t2_completed", completed, 1);
      chk("t2_buffer", buffer, exp_line(SEED2));
      chk("t2_offset", offset, 63);
      chk("t2_num_bytes", num_bytes, 1);
      tick(); tick();
      chk("t2_completed_held", completed, 1);
      send = 1'b0;
      tick();
      chk("t2_completed_low", completed, 0);

      // 3: client drops request during FILL after beat 3
      request(64'h3008);
      ack_after(1);
      send_beats(0, 3, 0, SEED3);
      send = 1'b0;
      send_beats(4, 7, 0, SEED3);
      chk("t3_completed_pulse", completed, 1);
      chk("t3_buffer", buffer, exp_line(SEED3));
      chk("t3_offset", offset, 8);
      chk("t3_num_bytes", num_bytes, 56);
      tick();
      chk("t3_completed_low", completed, 0);
      tick(); tick(); tick();
      chk("t3_no_second_req", bus_req, 0);
      chk("t3_still_idle", completed, 0);

      // reset during REQ drops bus_req without a clock
      request(64'h6000);
      chk("rreq_bus_req", bus_req, 1);
      reset = 1'b0;
      #1;
      chk("rreq_bus_req_async", bus_req, 0);
      send = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      // 4: reset after beat 4; late beats ignored; then a normal fetch
      request(64'h4000);
      ack_after(1);
      send_beats(0, 4, 0, SEED4);
      reset = 1'b0;
      #1;
      chk("t4_buffer_cleared", buffer, '0);
      chk("t4_bus_addr_cleared", bus_addr, 0);
      chk("t4_completed", completed, 0);
      send = 1'b0;
      tick(); tick();
      reset = 1'b1;
      send_beats(5, 7, 0, SEED4);
      tick();
      chk("t4_late_beats_ignored", buffer, '0);
      chk("t4_no_completed", completed, 0);
      chk("t4_no_bus_req", bus_req, 0);
      request(64'h5010);
      chk("t4_next_bus_addr", bus_addr, 64'h5000);
      ack_after(2);
      send_beats(0, 7, 0, SEED5);
      chk("t4_next_buffer", buffer, exp_line(SEED5));
      chk("t4_next_offset", offset, 16);
      chk("t4_next_num_bytes", num_bytes, 48);
      send = 1'b0;
      tick();

      // 5/6: same-line second request
      request(64'h1000);
      ack_after(1);
      send_beats(0, 7, 0, SEED1);
      chk("t56_first_completed", completed, 1);
      send = 1'b0;
      tick();
      request(64'h1010);
`ifdef LOAD_LINE_HIT_EN
      chk("t5_no_bus_req", bus_req, 0);
      chk("t5_completed", completed, 1);
      chk("t5_offset", offset, 16);
      chk("t5_num_bytes", num_bytes, 48);
      chk("t5_buffer_unchanged", buffer, bytes_n);
`else
      chk("t6_bus_req", bus_req, 1);
      chk("t6_bus_addr", bus_addr, 64'h1000);
      chk("t6_not_completed", completed, 0);
      ack_after(1);
      send_beats(0, 7, 0, SEED1);
      chk("t6_completed", completed, 1);
      chk("t6_offset", offset, 16);
      chk("t6_num_bytes", num_bytes, 48);
`endif
      send = 1'b0;
      tick();
      chk("t56_completed_low", completed, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
